fb_pipestage: RTL and testbench
===============================

# fb_pipestage

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer: the generic successor to the fixed EX/MEM latch. It is placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a control bundle and a data bundle. It adds backpressure without a combinational ready path, a flush that cancels control side effects, and occupancy reporting.

## Interface
Parameters:
- DATA_W, default 96: width of the data bundle (for example alu_res, rs2_data and pc concatenated).
- CTRL_W, default 16: width of the control bundle (for example mem_read, mem_write, reg_write, rd). It is zeroed whenever its entry is invalid.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserting 0 clears state immediately).
- flush  input  1  synchronous cancel of all held entries.
- in_valid  input  1  upstream offers in_ctrl/in_data.
- in_ready  output  1  stage can accept; registered.
- in_ctrl  input  CTRL_W  control bundle from upstream.
- in_data  input  DATA_W  data bundle from upstream.
- out_valid  output  1  out_ctrl/out_data hold a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_ctrl  output  CTRL_W  control bundle; all-zero when out_valid=0.
- out_data  output  DATA_W  data bundle; undefined-but-stable when out_valid=0.
- occupancy  output  2  number of held entries (0, 1, 2).

## Operation
- Storage: main entry (main_v, main_ctrl, main_data) drives the outputs. Skid entry (skid_v, skid_ctrl, skid_data) absorbs one beat under backpressure.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). skid_v=1 with main_v=0 is illegal and never reached.
- Handshake events: accept = in_valid & in_ready; release = out_valid & out_ready.
- in_ready = !skid_v (registered state bit; no combinational path from out_ready).
- EMPTY:
  - accept: load main, go to ONE.
  - otherwise: stay in EMPTY.
- ONE:
  - accept & release: load main from the input, stay in ONE.
  - accept & !release: load skid, go to FULL.
  - !accept & release: go to EMPTY.
  - neither: hold.
- FULL (no accept is possible):
  - release: main <= skid, skid_v <= 0, go to ONE.
  - otherwise: hold.
- Ordering is strictly FIFO; an entry is never duplicated or dropped except by flush.
- flush has priority over every handshake event:
  - Next state is EMPTY; main_v, skid_v, main_ctrl and skid_ctrl are cleared to 0.
  - A beat accepted in the same cycle is discarded.
  - Data registers may keep stale contents.
- Invariant: whenever a valid bit is 0, its ctrl register is 0. Every transition that clears a valid bit also clears the matching ctrl.
- occupancy = main_v + skid_v.
- Stall: holding out_ready=0 freezes the outputs, which replaces the old `we` enable.
- Bubble: holding in_valid=0 while downstream consumes yields out_valid=0 and out_ctrl=0, which replaces manual zero-injection.

## Timing
- Reset (rst=0, asynchronous):
  - main_v = skid_v = 0; all ctrl and data registers = 0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Deassertion of rst takes effect at the next rising edge; the first accept is possible on that edge.
- Latency: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when the stage was EMPTY, or when it was ONE and released at N.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_ready falls in the cycle after the stage enters FULL and rises in the cycle after the first release from FULL.
- Reset mid-operation discards all entries regardless of the handshake.
- flush and rst both asserted: reset wins (same end state).

## Test plan
- Reset values:
  - Drive rst=0 while in_valid=1, in_ctrl=16'hFFFF.
  - Require out_valid=0, out_ctrl=0, out_data=0, occupancy=0 and in_ready=1 during reset and on the first cycle after release.
- Streaming:
  - Hold out_ready=1 and present beats D0..D7 = 32'h100+i on consecutive cycles.
  - Each beat must appear exactly one cycle later, in order, with no gaps.
- Backpressure fill and drain:
  - With out_ready=0, send A then B. Require occupancy=2, in_ready=0 and out_data=A held.
  - Offer C while in_ready=0: it must not be accepted.
  - Raise out_ready: outputs must be A, then B, then C, with in_ready=1 one cycle after A is released.
- Flush while full:
  - In FULL, assert flush together with in_valid=1 carrying ctrl=16'h0007.
  - Next cycle require occupancy=0, out_valid=0 and out_ctrl=0; the offered beat never appears.
- Ctrl zeroing on bubble:
  - Send one beat with ctrl=16'h00A5, then in_valid=0, with out_ready=1.
  - Require out_ctrl=16'h00A5 for one cycle, then 0 with out_valid=0.
- Reset mid-burst:
  - With occupancy=2, pulse rst=0 asynchronously between edges.
  - Outputs must clear immediately, without waiting for a clock edge; after release, new beat E0 passes with one-cycle latency.

Source files
------------

// File: rtl/fb_pipestage.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// The ready signal is decoded only from registered state, so there is no combinational path from out_ready.
module fb_pipestage #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_main_v;
  logic w_skid_v;
  logic w_accept;
  logic w_release;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clr_main;

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // flush overrides every handshake; a beat accepted alongside it is discarded
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_next = S_ONE;
      S_ONE: begin
        if (w_accept && !w_release)      w_state_next = S_FULL;
        else if (!w_accept && w_release) w_state_next = S_EMPTY;
      end
      S_FULL:  if (w_release) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
    if (flush) w_state_next = S_EMPTY;
  end

  always_comb begin
    w_main_v         = (r_state == S_ONE) || (r_state == S_FULL);
    w_skid_v         = (r_state == S_FULL);
    in_ready         = !w_skid_v;
    out_valid        = w_main_v;
    out_ctrl         = r_main_ctrl;
    out_data         = r_main_data;
    occupancy        = {1'b0, w_main_v} + {1'b0, w_skid_v};
    w_load_main_in   = w_accept && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_release));
    w_load_skid      = w_accept && (r_state == S_ONE) && !w_release;
    w_load_main_skid = (r_state == S_FULL) && w_release;
    w_clr_main       = (r_state == S_ONE) && w_release && !w_accept;
  end

  // ctrl is zeroed on every transition that invalidates its entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end else if (w_clr_main) begin
        r_main_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end else if (w_load_main_skid) begin
        r_skid_ctrl <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_pipestage.sv
// Scoreboard bench for fb_pipestage: stimulus pushes expected beats, a negedge monitor pops on each release.
module tb_fb_pipestage;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail = 0;
  beat_t exp_q[$];

  fb_pipestage #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    if (expect_out) exp_q.push_back('{c: c, d: d});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got ctrl=%0h data=%0h, expected none", out_ctrl, out_data);
      end else begin
        e = exp_q.pop_front();
        $display("beat ctrl=%04h data=%08h (expected ctrl=%04h data=%08h)", out_ctrl, out_data, e.c, e.d);
        chk("mon_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("mon_data", 64'(out_data), 64'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with an aggressive offer on the input
    #1 rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'hDEAD_BEEF;
    #2;
    chk_idle("rst_during");
    chk("rst_out_data", 64'(out_data), 64'd0);
    step(); step();
    chk_idle("rst_held");
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk_idle("rst_after");
    chk("rst_after_out_data", 64'(out_data), 64'd0);

    // streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(16'(i + 1), 32'h100 + 32'(i), 1'b1);
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data",  64'(out_data),  64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_ctrl",  64'(out_ctrl),  64'd0);

    // single beat followed by a bubble
    drive(16'h00A5, 32'h55, 1'b1);
    step();
    chk("bubble_ctrl_hold", 64'(out_ctrl), 64'h00A5);
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl",  64'(out_ctrl),  64'd0);

    // backpressure fill and drain
    out_ready = 1'b0;
    drive(16'h0011, 32'hA, 1'b1);
    step();
    drive(16'h0012, 32'hB, 1'b1);
    step();
    chk("bp_occ_full",  64'(occupancy), 64'd2);
    chk("bp_ready_low", 64'(in_ready),  64'd0);
    chk("bp_hold_a",    64'(out_data),  64'hA);
    drive(16'h0013, 32'hC, 1'b1);
    step();
    chk("bp_c_refused_occ", 64'(occupancy), 64'd2);
    chk("bp_c_refused_out", 64'(out_data),  64'hA);
    out_ready = 1'b1;
    step();
    chk("bp_out_b",     64'(out_data),  64'hB);
    chk("bp_ready_up",  64'(in_ready),  64'd1);
    chk("bp_occ_one",   64'(occupancy), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c",     64'(out_data),  64'hC);
    chk("bp_out_c_ctl", 64'(out_ctrl),  64'h0013);
    step();
    chk("bp_empty_occ", 64'(occupancy), 64'd0);

    // flush while full, with a beat offered in the same cycle
    out_ready = 1'b0;
    drive(16'h0021, 32'hF0, 1'b0);
    step();
    drive(16'h0022, 32'hF1, 1'b0);
    step();
    chk("fl_occ_full", 64'(occupancy), 64'd2);
    flush = 1'b1;
    drive(16'h0007, 32'h77, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_idle("fl_after");
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    drive(16'h0031, 32'h60, 1'b0);
    step();
    drive(16'h0032, 32'h61, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mr_occ_full", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk_idle("mr_async");
    chk("mr_async_data", 64'(out_data), 64'd0);
    #2 rst = 1'b1;
    step();
    out_ready = 1'b1;
    drive(16'h003C, 32'hE0, 1'b1);
    step();
    chk("mr_e0_valid", 64'(out_valid), 64'd1);
    chk("mr_e0_data",  64'(out_data),  64'hE0);
    chk("mr_e0_ctrl",  64'(out_ctrl),  64'h003C);
    in_valid = 1'b0;
    step();
    chk("mr_e0_gone", 64'(out_valid), 64'd0);
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
